// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encodings,
// default cycle constants and the counter width helper.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        SEQUENCE  = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } supState_e;

    localparam int DEF_NUM_CH           = 4;
    localparam int DEF_RST_PULSE_CYC    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_SEQ_GAP_CYC      = 8;
    localparam int DEF_MAX_RETRY        = 4;
    localparam int DEF_CNT_W            = 8;

    // Bits needed for a counter that only ever holds values below maxVal.
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal);
    endfunction

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow, level-type status bits crossing into the
// local clock domain. Each bit is synchronised independently, so it is only
// suitable for signals whose bits do not need to be sampled coherently.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the downstream reset domains one by one. Lock loss re-resets the
// PLL; repeated lock timeouts end in a sticky fault.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_CH           = DEF_NUM_CH,
    parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int SEQ_GAP_CYC      = DEF_SEQ_GAP_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY,
    parameter int CNT_W            = DEF_CNT_W
) (
    input  logic                           clkin1,
    input  logic                           pll_rst,
    input  logic                           pll_lock,
    output logic                           pll_rst_req,
    output logic [NUM_CH-1:0]              ch_rst,
    output logic                           all_ready,
    output logic                           fault,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [CNT_W-1:0]               lock_lost_cnt,
    output logic [2:0]                     state
);

    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int SEQ_SPAN = (NUM_CH - 1) * SEQ_GAP_CYC;
    localparam int TMR_W    = cntWidth(maxOf(maxOf(RST_PULSE_CYC, LOCK_TIMEOUT_CYC),
                                             maxOf(LOCK_STABLE_CYC, SEQ_SPAN + 1)));

    localparam logic [TMR_W-1:0]   PULSE_LAST   = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST  = TMR_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMR_W-1:0]   SEQ_LAST     = TMR_W'(SEQ_SPAN);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    supState_e          state_q, state_d;
    logic [TMR_W-1:0]   pulseCnt_q, pulseCnt_d;
    logic [TMR_W-1:0]   timeoutCnt_q, timeoutCnt_d;
    logic [TMR_W-1:0]   stableCnt_q, stableCnt_d;
    logic [TMR_W-1:0]   seqCnt_q, seqCnt_d;
    logic [NUM_CH-1:0]  chRst_q, chRst_d;
    logic               allReady_q, allReady_d;
    logic               fault_q, fault_d;
    logic               pllRstReq_q, pllRstReq_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]   lostCnt_q, lostCnt_d;

    logic               lockS;
    logic               lockLoss;
    logic               timeoutHit;
    logic [RETRY_W-1:0] retryInc;
    logic [TMR_W-1:0]   stableInc;

    sync_2ff #(
        .WIDTH (1)
    ) uLockSync (
        .clock_i (clkin1),
        .reset_i (pll_rst),
        .d_i     (pll_lock),
        .q_o     (lockS)
    );

    // State, timers and every output are registered together so the outputs
    // always describe the state the FSM is currently in.
    always_ff @(posedge clkin1 or posedge pll_rst) begin
        if (pll_rst) begin
            state_q      <= RESET_PLL;
            pulseCnt_q   <= '0;
            timeoutCnt_q <= '0;
            stableCnt_q  <= '0;
            seqCnt_q     <= '0;
            chRst_q      <= '1;
            allReady_q   <= 1'b0;
            fault_q      <= 1'b0;
            pllRstReq_q  <= 1'b1;
            retry_q      <= '0;
            lostCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pulseCnt_q   <= pulseCnt_d;
            timeoutCnt_q <= timeoutCnt_d;
            stableCnt_q  <= stableCnt_d;
            seqCnt_q     <= seqCnt_d;
            chRst_q      <= chRst_d;
            allReady_q   <= allReady_d;
            fault_q      <= fault_d;
            pllRstReq_q  <= pllRstReq_d;
            retry_q      <= retry_d;
            lostCnt_q    <= lostCnt_d;
        end
    end

    // Next-state logic. The timeout timer keeps running across STABLE and
    // WAIT_LOCK, so a chattering lock cannot restart it; it saturates rather
    // than wrapping. The stable count includes the WAIT_LOCK cycle that first
    // saw lock high, hence the comparison on the incremented value.
    always_comb begin
        state_d      = state_q;
        pulseCnt_d   = pulseCnt_q;
        timeoutCnt_d = timeoutCnt_q;
        stableCnt_d  = stableCnt_q;
        seqCnt_d     = seqCnt_q;
        chRst_d      = chRst_q;
        allReady_d   = allReady_q;
        fault_d      = fault_q;
        pllRstReq_d  = pllRstReq_q;
        retry_d      = retry_q;
        lostCnt_d    = lostCnt_q;
        lockLoss     = 1'b0;
        retryInc     = retry_q + RETRY_W'(1);
        stableInc    = stableCnt_q + TMR_W'(1);
        timeoutHit   = (timeoutCnt_q >= TIMEOUT_LAST);

        case (state_q)
            RESET_PLL: begin
                if (pulseCnt_q >= PULSE_LAST) begin
                    state_d      = WAIT_LOCK;
                    timeoutCnt_d = '0;
                end else begin
                    pulseCnt_d = pulseCnt_q + TMR_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (!timeoutHit) begin
                    timeoutCnt_d = timeoutCnt_q + TMR_W'(1);
                end
                if (lockS) begin
                    state_d     = STABLE;
                    stableCnt_d = '0;
                end else if (timeoutHit) begin
                    retry_d = retryInc;
                    state_d = (retryInc == RETRY_LIMIT) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (!timeoutHit) begin
                    timeoutCnt_d = timeoutCnt_q + TMR_W'(1);
                end
                if (lockS && (stableInc >= STABLE_LAST)) begin
                    state_d  = SEQUENCE;
                    seqCnt_d = '0;
                end else if (timeoutHit) begin
                    retry_d = retryInc;
                    state_d = (retryInc == RETRY_LIMIT) ? FAULT : RESET_PLL;
                end else if (!lockS) begin
                    state_d = WAIT_LOCK;
                end else begin
                    stableCnt_d = stableInc;
                end
            end
            SEQUENCE: begin
                if (!lockS) begin
                    lockLoss = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (seqCnt_q == TMR_W'(k * SEQ_GAP_CYC)) begin
                            chRst_d[k] = 1'b0;
                        end
                    end
                    if (seqCnt_q >= SEQ_LAST) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        seqCnt_d = seqCnt_q + TMR_W'(1);
                    end
                end
            end
            RUN: begin
                if (!lockS) begin
                    lockLoss = 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (lockLoss) begin
            state_d = RESET_PLL;
            if (lostCnt_q != '1) begin
                lostCnt_d = lostCnt_q + CNT_W'(1);
            end
        end

        if ((state_d == RESET_PLL) && (state_q != RESET_PLL)) begin
            pulseCnt_d = '0;
        end

        if ((state_d != SEQUENCE) && (state_d != RUN)) begin
            chRst_d = '1;
        end
        allReady_d  = (state_d == RUN);
        fault_d     = (state_d == FAULT);
        pllRstReq_d = (state_d == RESET_PLL) || (state_d == FAULT);
    end

    assign pll_rst_req   = pllRstReq_q;
    assign ch_rst        = chRst_q;
    assign all_ready     = allReady_q;
    assign fault         = fault_q;
    assign retry_cnt     = retry_q;
    assign lock_lost_cnt = lostCnt_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor with a small, fast configuration.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pll_lock_supervisor;

    localparam int NUM_CH = 3;
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_SEQ   = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic              clkin1 = 1'b0;
    logic              pll_rst = 1'b1;
    logic              pll_lock = 1'b0;
    logic              pll_rst_req;
    logic [NUM_CH-1:0] ch_rst;
    logic              all_ready;
    logic              fault;
    logic [1:0]        retry_cnt;
    logic [7:0]        lock_lost_cnt;
    logic [2:0]        state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int expQ[$];

    pll_lock_supervisor #(
        .NUM_CH           (NUM_CH),
        .RST_PULSE_CYC    (4),
        .LOCK_TIMEOUT_CYC (100),
        .LOCK_STABLE_CYC  (10),
        .SEQ_GAP_CYC      (3),
        .MAX_RETRY        (2),
        .CNT_W            (8)
    ) dut (
        .clkin1        (clkin1),
        .pll_rst       (pll_rst),
        .pll_lock      (pll_lock),
        .pll_rst_req   (pll_rst_req),
        .ch_rst        (ch_rst),
        .all_ready     (all_ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_lost_cnt (lock_lost_cnt),
        .state         (state)
    );

    always #5 clkin1 = ~clkin1;

    task automatic tick();
        @(posedge clkin1);
        #1;
        cyc++;
    endtask

    task automatic tickTo(input int t);
        while (cyc < t) tick();
    endtask

    // Leaves the DUT just released from reset; the caller's tick 0 is now.
    task automatic startFromReset(input logic lockVal);
        pll_lock = 1'b0;
        pll_rst  = 1'b1;
        tick();
        tick();
        pll_rst  = 1'b0;
        pll_lock = lockVal;
    endtask

    task automatic test_reset();
        pll_rst  = 1'b1;
        pll_lock = 1'b0;
        tick();
        total++; if (state !== S_RESET) begin bad++; $display("[TB] FAIL reset_state: got %0d want %0d", state, S_RESET); end
        total++; if (pll_rst_req !== 1'b1) begin bad++; $display("[TB] FAIL reset_req: got %b want 1", pll_rst_req); end
        total++; if (ch_rst !== 3'b111) begin bad++; $display("[TB] FAIL reset_ch: got %b want 111", ch_rst); end
        total++; if (all_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", all_ready); end
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault: got %b want 0", fault); end
        total++; if (retry_cnt !== 2'd0) begin bad++; $display("[TB] FAIL reset_retry: got %0d want 0", retry_cnt); end
        total++; if (lock_lost_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_lost: got %0d want 0", lock_lost_cnt); end
    endtask

    task automatic test_nominal();
        int rel, lockT, n, e;
        int fallT[NUM_CH];
        startFromReset(1'b0);
        rel = cyc;
        expQ.push_back(4);
        n = 0;
        while (pll_rst_req === 1'b1 && n < 20) begin tick(); n++; end
        e = expQ.pop_front();
        total++; if (n !== e) begin bad++; $display("[TB] FAIL nom_rst_pulse: got %0d want %0d", n, e); end

        tickTo(rel + 20);
        pll_lock = 1'b1;
        lockT = cyc;
        expQ.push_back(13); expQ.push_back(16); expQ.push_back(19);
        for (int k = 0; k < NUM_CH; k++) fallT[k] = -1;
        for (int t = 0; t < 40; t++) begin
            tick();
            for (int k = 0; k < NUM_CH; k++) begin
                if (fallT[k] < 0 && ch_rst[k] === 1'b0) fallT[k] = cyc - lockT;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            e = expQ.pop_front();
            total++; if (fallT[k] !== e) begin bad++; $display("[TB] FAIL nom_ch%0d_fall: got %0d want %0d", k, fallT[k], e); end
        end
        total++; if (all_ready !== 1'b1) begin bad++; $display("[TB] FAIL nom_ready: got %b want 1", all_ready); end
        total++; if (retry_cnt !== 2'd0) begin bad++; $display("[TB] FAIL nom_retry: got %0d want 0", retry_cnt); end
        total++; if (state !== S_RUN) begin bad++; $display("[TB] FAIL nom_state: got %0d want %0d", state, S_RUN); end
    endtask

    task automatic test_lock_chatter();
        int rel, riseT, fallT, retryAtRise, e;
        logic sawSeq, seenLow;
        startFromReset(1'b1);
        rel = cyc;
        expQ.push_back(104); expQ.push_back(1); expQ.push_back(108);
        sawSeq = 1'b0; seenLow = 1'b0;
        riseT = -1; fallT = -1; retryAtRise = -1;
        for (int t = 0; t < 115; t++) begin
            pll_lock = ((t % 8) != 7);
            tick();
            if (state === S_SEQ || state === S_RUN) sawSeq = 1'b1;
            if (pll_rst_req === 1'b0) seenLow = 1'b1;
            if (seenLow && riseT < 0 && pll_rst_req === 1'b1) begin
                riseT = cyc - rel;
                retryAtRise = int'(retry_cnt);
            end
            if (riseT >= 0 && fallT < 0 && pll_rst_req === 1'b0) fallT = cyc - rel;
        end
        e = expQ.pop_front();
        total++; if (riseT !== e) begin bad++; $display("[TB] FAIL chat_req_rise: got %0d want %0d", riseT, e); end
        e = expQ.pop_front();
        total++; if (retryAtRise !== e) begin bad++; $display("[TB] FAIL chat_retry: got %0d want %0d", retryAtRise, e); end
        e = expQ.pop_front();
        total++; if (fallT !== e) begin bad++; $display("[TB] FAIL chat_req_fall: got %0d want %0d", fallT, e); end
        total++; if (sawSeq !== 1'b0) begin bad++; $display("[TB] FAIL chat_no_seq: got %b want 0", sawSeq); end
    endtask

    task automatic test_timeout_race();
        int rel;
        startFromReset(1'b0);
        rel = cyc;
        tickTo(rel + 101);
        pll_lock = 1'b1;
        tickTo(rel + 103);
        total++; if (state !== S_WAIT) begin bad++; $display("[TB] FAIL race_pre_state: got %0d want %0d", state, S_WAIT); end
        tick();
        total++; if (state !== S_STAB) begin bad++; $display("[TB] FAIL race_state: got %0d want %0d", state, S_STAB); end
        total++; if (retry_cnt !== 2'd0) begin bad++; $display("[TB] FAIL race_retry: got %0d want 0", retry_cnt); end
    endtask

    task automatic test_no_lock();
        int rel, faultT, retryAtFault, e;
        startFromReset(1'b0);
        rel = cyc;
        expQ.push_back(208); expQ.push_back(2);
        faultT = -1; retryAtFault = -1;
        for (int t = 0; t < 230; t++) begin
            tick();
            if (faultT < 0 && fault === 1'b1) begin
                faultT = cyc - rel;
                retryAtFault = int'(retry_cnt);
            end
        end
        e = expQ.pop_front();
        total++; if (faultT !== e) begin bad++; $display("[TB] FAIL nolock_fault_time: got %0d want %0d", faultT, e); end
        e = expQ.pop_front();
        total++; if (retryAtFault !== e) begin bad++; $display("[TB] FAIL nolock_retry: got %0d want %0d", retryAtFault, e); end
        total++; if (fault !== 1'b1) begin bad++; $display("[TB] FAIL nolock_sticky: got %b want 1", fault); end
        total++; if (pll_rst_req !== 1'b1) begin bad++; $display("[TB] FAIL nolock_req: got %b want 1", pll_rst_req); end
        total++; if (ch_rst !== 3'b111) begin bad++; $display("[TB] FAIL nolock_ch: got %b want 111", ch_rst); end
        total++; if (state !== S_FAULT) begin bad++; $display("[TB] FAIL nolock_state: got %0d want %0d", state, S_FAULT); end
        pll_rst = 1'b1;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("[TB] FAIL nolock_clear: got %b want 0", fault); end
    endtask

    task automatic test_lock_loss_run();
        int rel, d0, readyT, e;
        startFromReset(1'b0);
        rel = cyc;
        tickTo(rel + 20);
        pll_lock = 1'b1;
        tickTo(rel + 39);
        d0 = cyc;
        pll_lock = 1'b0;
        expQ.push_back(1);
        tick();
        pll_lock = 1'b1;
        tick();
        total++; if (ch_rst !== 3'b000 || all_ready !== 1'b1) begin bad++; $display("[TB] FAIL run_loss_early: got ch=%b rdy=%b want ch=000 rdy=1", ch_rst, all_ready); end
        tick();
        total++; if (ch_rst !== 3'b111) begin bad++; $display("[TB] FAIL run_loss_ch: got %b want 111", ch_rst); end
        total++; if (all_ready !== 1'b0) begin bad++; $display("[TB] FAIL run_loss_ready: got %b want 0", all_ready); end
        e = expQ.pop_front();
        total++; if (lock_lost_cnt !== 8'(e)) begin bad++; $display("[TB] FAIL run_loss_cnt: got %0d want %0d", lock_lost_cnt, e); end
        expQ.push_back(24);
        readyT = -1;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (readyT < 0 && all_ready === 1'b1) readyT = cyc - d0;
        end
        e = expQ.pop_front();
        total++; if (readyT !== e) begin bad++; $display("[TB] FAIL run_loss_reseq: got %0d want %0d", readyT, e); end
    endtask

    task automatic test_loss_in_sequence();
        int rel, l0, readyT, e;
        logic sawRun;
        startFromReset(1'b0);
        rel = cyc;
        tickTo(rel + 20);
        pll_lock = 1'b1;
        l0 = cyc;
        tickTo(l0 + 13);
        total++; if (ch_rst !== 3'b110) begin bad++; $display("[TB] FAIL seq_loss_pre: got %b want 110", ch_rst); end
        pll_lock = 1'b0;
        expQ.push_back(1);
        tick();
        pll_lock = 1'b1;
        sawRun = 1'b0;
        tickTo(l0 + 16);
        total++; if (ch_rst !== 3'b111) begin bad++; $display("[TB] FAIL seq_loss_ch: got %b want 111", ch_rst); end
        e = expQ.pop_front();
        total++; if (lock_lost_cnt !== 8'(e)) begin bad++; $display("[TB] FAIL seq_loss_cnt: got %0d want %0d", lock_lost_cnt, e); end
        expQ.push_back(37);
        readyT = -1;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (state === S_RUN && cyc < l0 + 37) sawRun = 1'b1;
            if (readyT < 0 && all_ready === 1'b1) readyT = cyc - l0;
        end
        total++; if (sawRun !== 1'b0) begin bad++; $display("[TB] FAIL seq_loss_no_run: got %b want 0", sawRun); end
        e = expQ.pop_front();
        total++; if (readyT !== e) begin bad++; $display("[TB] FAIL seq_loss_reseq: got %0d want %0d", readyT, e); end
    endtask

    task automatic test_final_release_race();
        int rel, l0;
        startFromReset(1'b0);
        rel = cyc;
        tickTo(rel + 20);
        pll_lock = 1'b1;
        l0 = cyc;
        tickTo(l0 + 16);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tickTo(l0 + 18);
        total++; if (ch_rst !== 3'b100) begin bad++; $display("[TB] FAIL final_pre_ch: got %b want 100", ch_rst); end
        tick();
        total++; if (ch_rst !== 3'b111 || state !== S_RESET || all_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL final_race: got ch=%b st=%0d rdy=%b want ch=111 st=0 rdy=0", ch_rst, state, all_ready);
        end
    endtask

    task automatic test_saturation();
        int n, e;
        logic aborted;
        startFromReset(1'b1);
        aborted = 1'b0;
        for (int i = 0; i < 256 && !aborted; i++) begin
            n = 0;
            while (state !== S_RUN && n < 100) begin tick(); n++; end
            if (state !== S_RUN) begin
                total++; bad++;
                $display("[TB] FAIL sat_wait_run: got state %0d want %0d at loss %0d", state, S_RUN, i);
                aborted = 1'b1;
            end else begin
                pll_lock = 1'b0;
                expQ.push_back((i + 1 > 255) ? 255 : i + 1);
                tick();
                pll_lock = 1'b1;
                tick();
                tick();
                e = expQ.pop_front();
                total++; if (lock_lost_cnt !== 8'(e)) begin bad++; $display("[TB] FAIL sat_cnt: got %0d want %0d", lock_lost_cnt, e); end
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        int n;
        n = 0;
        while (!(state === S_SEQ && ch_rst[0] === 1'b0) && n < 100) begin tick(); n++; end
        total++; if (state !== S_SEQ) begin bad++; $display("[TB] FAIL mid_reach_seq: got %0d want %0d", state, S_SEQ); end
        pll_rst = 1'b1;
        #1;
        total++; if (state !== S_RESET) begin bad++; $display("[TB] FAIL mid_state: got %0d want 0", state); end
        total++; if (pll_rst_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_req: got %b want 1", pll_rst_req); end
        total++; if (ch_rst !== 3'b111) begin bad++; $display("[TB] FAIL mid_ch: got %b want 111", ch_rst); end
        total++; if (all_ready !== 1'b0 || fault !== 1'b0) begin bad++; $display("[TB] FAIL mid_flags: got rdy=%b flt=%b want 0 0", all_ready, fault); end
        total++; if (retry_cnt !== 2'd0) begin bad++; $display("[TB] FAIL mid_retry: got %0d want 0", retry_cnt); end
        total++; if (lock_lost_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_lost: got %0d want 0", lock_lost_cnt); end
        tick();
        pll_rst = 1'b0;
    endtask

    initial begin
        $display("[TB] starting pll_lock_supervisor bench");
        test_reset();
        test_nominal();
        test_lock_chatter();
        test_timeout_race();
        test_no_lock();
        test_lock_loss_run();
        test_loss_in_sequence();
        test_final_release_race();
        test_saturation();
        test_reset_mid_sequence();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
